stage_execute_md: RTL
=====================

// Module: stage_execute_md
// PURPOSE
//  Parametrised execute stage. Adds an iterative multiply/divide unit, a valid/ready handshake
//  on both sides, and a registered EX/MEM output. Resolves addi/lw/sw operand selection,
//  R-type ALU ops, and bne/blt/bex/j/jal/jr redirects.
//  Sits between the decode/regfile-read latch and the memory stage.
//  Stalls upstream while a mul/div is in flight.
// PARAMETERS
//  WIDTH      32  datapath and PC width
//  IMM_W      17  immediate width; sign-extended to WIDTH
//  TGT_W      27  jump target width; PC upper bits = WIDTH-TGT_W
//  MD_CYCLES  32  iterations of mul/div unit (1 bit per cycle; must equal WIDTH)
// PORTS
//  clock         in   1           rising-edge clock
//  reset_n       in   1           asynchronous, active-low reset
//  flush         in   1           sync kill of in-flight and output instruction
//  in_valid      in   1           decode presents an instruction
//  in_ready      out  1           stage can accept this cycle
//  opcode        in   5           instruction opcode
//  alu_op        in   5           R-type function
//  shamt         in   5           shift amount
//  immediate     in   IMM_W       I-type immediate
//  target        in   TGT_W       J-type target
//  rf_a          in   WIDTH       regfile operand A ($rs / $rstatus for bex)
//  rf_b          in   WIDTH       regfile operand B ($rd)
//  pc_plus_4     in   WIDTH       PC of next sequential instruction
//  out_valid     out  1           registered result valid
//  out_ready     in   1           memory stage accepts result
//  alu_result    out  WIDTH       registered result
//  store_data    out  WIDTH       registered rf_b (for sw)
//  take_branch   out  1           registered redirect request
//  pc_in         out  WIDTH       registered next-PC
//  ovf           out  1           add/sub/mul overflow
//  div_zero      out  1           div with divisor 0
// BEHAVIOUR
//  Reset: every output is 0 and in_ready is 1; FSM enters IDLE. Asserting reset mid-operation
//   abandons the mul/div with no output.
//  Operand B select:
//   - addi 00101, sw 00111, lw 01000 -> sext(immediate)
//   - bex 10110 -> 0
//   - otherwise -> rf_b
//  Operand A is always rf_a.
//  Accept occurs when in_valid & in_ready.
//   in_ready = (state==IDLE) & (~out_valid | out_ready).
//  Single-cycle op: the result registers on the accept edge (latency 1).
//  Mul/div: R-type with alu_op 00110 (mul) or 00111 (div) takes IDLE->BUSY on accept.
//   - BUSY: iteration counter counts 0..MD_CYCLES-1; in_ready=0.
//   - On the last count the result registers, out_valid=1, and the FSM returns to IDLE.
//   - Latency is MD_CYCLES+1.
//   - Signed operands.
//   - mul: keep the low WIDTH bits; ovf=1 if the full product does not fit in signed WIDTH.
//   - div: truncates toward zero.
//   - div by 0: alu_result=0, div_zero=1.
//   - div of MIN by -1: result MIN, ovf=1.
//  Backpressure: when out_valid & ~out_ready, all outputs hold. A BUSY op that completes in
//   this condition waits in BUSY at its final count until the output frees.
//  Branch resolution (registered with result):
//   - bne 00010: taken if rf_a!=rf_b.
//   - blt 00110: taken if signed rf_b < rf_a.
//   - bex: taken if rf_a!=0.
//   - j 00001 / jal 00011 / taken bex: pc_in = {pc_plus_4[WIDTH-1:TGT_W], target}.
//   - taken bne/blt: pc_in = pc_plus_4 + sext(imm), mod 2^WIDTH.
//   - jr 00100: pc_in = rf_b.
//   - otherwise: pc_in = pc_plus_4.
//   - take_branch=1 for taken bne/blt/bex, j, jal, jr.
//  flush: next edge clears out_valid and take_branch. BUSY goes to IDLE and the result is
//   discarded. flush wins over a simultaneous accept (instruction dropped).
//  jal result: alu_result = pc_plus_4.
//  ovf: set on signed add/sub overflow; cleared with each new result.
// TESTING
//  1. addi rf_a=5, imm=-3 -> next cycle out_valid=1, alu_result=2, in_ready stays 1.
//  2. mul rf_a=-7, rf_b=6 -> in_ready=0 for 32 cycles; cycle 33: alu_result=-42, ovf=0.
//  3. div rf_a=100, rf_b=0 -> after 33 cycles: alu_result=0, div_zero=1.
//  4. bne rf_a=1, rf_b=2, pc_plus_4=0x100, imm=-4 -> take_branch=1, pc_in=0xFC.
//     Then blt with rf_a=rf_b -> take_branch=0.
//  5. mul issued with out_ready=0 held -> outputs frozen, in_ready=0; release -> result appears once.
//  6. flush on cycle 10 of a div, and reset_n low mid-mul -> out_valid stays 0, FSM IDLE, in_ready=1.

Source files
------------

// File: rtl/stage_execute_md.sv
// stage_execute_md
//   Execute stage between the decode/regfile-read latch and the memory stage.
//   It resolves operand B selection, single-cycle R-type ALU operations and
//   branch/jump redirects. It also contains an iterative signed multiply/divide
//   unit that retires one bit per cycle. A valid/ready handshake sits on both
//   sides, and the EX/MEM outputs are registered.
//
// Ports
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   flush              synchronous kill of the in-flight op and the output slot
//   in_valid/in_ready  upstream handshake; in_ready drops while a mul/div runs
//   opcode, alu_op,    decoded instruction fields
//   shamt, immediate,
//   target
//   rf_a, rf_b         register operands ($rs / $rstatus, $rd)
//   pc_plus_4          PC of the next sequential instruction
//   out_valid/out_ready downstream handshake for the registered result
//   alu_result         registered ALU / mul / div / link result
//   store_data         registered rf_b, used by sw
//   take_branch, pc_in registered redirect request and next PC
//   ovf, div_zero      add/sub/mul/div overflow and divide-by-zero flags
module stage_execute_md #(
  parameter int WIDTH     = 32,
  parameter int IMM_W     = 17,
  parameter int TGT_W     = 27,
  parameter int MD_CYCLES = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         opcode,
  input  logic [4:0]         alu_op,
  input  logic [4:0]         shamt,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [TGT_W-1:0]   target,
  input  logic [WIDTH-1:0]   rf_a,
  input  logic [WIDTH-1:0]   rf_b,
  input  logic [WIDTH-1:0]   pc_plus_4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_result,
  output logic [WIDTH-1:0]   store_data,
  output logic               take_branch,
  output logic [WIDTH-1:0]   pc_in,
  output logic               ovf,
  output logic               div_zero
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] FN_ADD = 5'b00000;
  localparam logic [4:0] FN_SUB = 5'b00001;
  localparam logic [4:0] FN_AND = 5'b00010;
  localparam logic [4:0] FN_OR  = 5'b00011;
  localparam logic [4:0] FN_SLL = 5'b00100;
  localparam logic [4:0] FN_SRA = 5'b00101;
  localparam logic [4:0] FN_MUL = 5'b00110;
  localparam logic [4:0] FN_DIV = 5'b00111;

  localparam int CNT_W = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] count;

  logic out_free, accept, is_md, is_div, md_done;
  logic [WIDTH-1:0] imm_ext, op_b, sum, diff, jump_pc, branch_pc;
  logic [WIDTH-1:0] sc_result, sc_pc;
  logic sc_ovf, sc_take;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Multiply/divide working registers. For mul, {md_acc, md_q} is the
  // shifting product and md_m is the multiplicand. For div, md_acc is the
  // partial remainder, md_q collects the quotient and md_m is the divisor.
  // All three hold magnitudes; the sign is applied once at the end.
  logic [WIDTH-1:0] md_acc, md_q, md_m, md_pc, md_store;
  logic md_is_div, md_neg, md_dz, md_minov;

  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   acc_next, q_next, quo_signed, md_result;
  logic [2*WIDTH-1:0] mul_mag, mul_signed;
  logic               md_ovf_fin;

  assign out_free  = ~out_valid | out_ready;
  assign is_md     = (opcode == OP_RTYPE) && (alu_op == FN_MUL || alu_op == FN_DIV);
  assign is_div    = (alu_op == FN_DIV);
  assign accept    = in_valid & in_ready & ~flush;
  assign md_done   = (state == BUSY) && (count == LAST) && out_free;
  assign imm_ext   = {{(WIDTH-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign jump_pc   = {pc_plus_4[WIDTH-1:TGT_W], target};
  assign branch_pc = pc_plus_4 + imm_ext;
  assign a_mag     = rf_a[WIDTH-1] ? -rf_a : rf_a;
  assign b_mag     = rf_b[WIDTH-1] ? -rf_b : rf_b;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake. A finished mul/div stays BUSY at its final
  // count until the output slot is free. Flush abandons it.
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE) && out_free;
    case (state)
      IDLE: if (accept && is_md) state_next = BUSY;
      BUSY: if (flush || md_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ALU and branch resolution.
  always_comb begin
    op_b = rf_b;
    case (opcode)
      OP_ADDI, OP_SW, OP_LW: op_b = imm_ext;
      OP_BEX:                op_b = '0;
      default:               op_b = rf_b;
    endcase
    sum       = rf_a + op_b;
    diff      = rf_a - op_b;
    sc_result = sum;
    sc_ovf    = 1'b0;
    sc_take   = 1'b0;
    sc_pc     = pc_plus_4;
    case (opcode)
      OP_RTYPE: begin
        case (alu_op)
          FN_ADD: begin
            sc_result = sum;
            sc_ovf = (rf_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != rf_a[WIDTH-1]);
          end
          FN_SUB: begin
            sc_result = diff;
            sc_ovf = (rf_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != rf_a[WIDTH-1]);
          end
          FN_AND:  sc_result = rf_a & op_b;
          FN_OR:   sc_result = rf_a | op_b;
          FN_SLL:  sc_result = rf_a << shamt;
          FN_SRA:  sc_result = $unsigned($signed(rf_a) >>> shamt);
          default: sc_result = '0;
        endcase
      end
      OP_BNE: if (rf_a != rf_b) begin
        sc_take = 1'b1;
        sc_pc   = branch_pc;
      end
      OP_BLT: if ($signed(rf_b) < $signed(rf_a)) begin
        sc_take = 1'b1;
        sc_pc   = branch_pc;
      end
      OP_BEX: if (rf_a != '0) begin
        sc_take = 1'b1;
        sc_pc   = jump_pc;
      end
      OP_J: begin
        sc_take = 1'b1;
        sc_pc   = jump_pc;
      end
      OP_JAL: begin
        sc_take   = 1'b1;
        sc_pc     = jump_pc;
        sc_result = pc_plus_4;
      end
      OP_JR: begin
        sc_take = 1'b1;
        sc_pc   = rf_b;
      end
      default: ;
    endcase
  end

  // One mul/div iteration. The mul step is shift-add. The div step is a
  // restoring shift-subtract. The final result is taken from this step's
  // output while the FSM sits at its last count.
  always_comb begin
    mul_sum   = {1'b0, md_acc} + (md_q[0] ? {1'b0, md_m} : '0);
    div_shift = {md_acc, md_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, md_m};
    if (md_is_div) begin
      acc_next = div_ge ? WIDTH'(div_shift - {1'b0, md_m}) : div_shift[WIDTH-1:0];
      q_next   = {md_q[WIDTH-2:0], div_ge};
    end else begin
      acc_next = mul_sum[WIDTH:1];
      q_next   = {mul_sum[0], md_q[WIDTH-1:1]};
    end
    mul_mag    = {acc_next, q_next};
    mul_signed = md_neg ? -mul_mag : mul_mag;
    quo_signed = md_neg ? -q_next : q_next;
    if (md_is_div) begin
      md_result  = md_dz ? '0 : quo_signed;
      md_ovf_fin = md_minov;
    end else begin
      md_result  = mul_signed[WIDTH-1:0];
      md_ovf_fin = mul_signed[2*WIDTH-1:WIDTH] != {WIDTH{mul_signed[WIDTH-1]}};
    end
  end

  // Mul/div operand capture and iteration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      md_acc    <= '0;
      md_q      <= '0;
      md_m      <= '0;
      md_pc     <= '0;
      md_store  <= '0;
      md_is_div <= 1'b0;
      md_neg    <= 1'b0;
      md_dz     <= 1'b0;
      md_minov  <= 1'b0;
    end else if (accept && is_md) begin
      count     <= '0;
      md_acc    <= '0;
      md_q      <= is_div ? a_mag : b_mag;
      md_m      <= is_div ? b_mag : a_mag;
      md_pc     <= pc_plus_4;
      md_store  <= rf_b;
      md_is_div <= is_div;
      md_neg    <= rf_a[WIDTH-1] ^ rf_b[WIDTH-1];
      md_dz     <= is_div && (rf_b == '0);
      md_minov  <= is_div && (rf_a == MIN_VAL) && (rf_b == '1);
    end else if (state == BUSY && count != LAST) begin
      count  <= count + 1'b1;
      md_acc <= acc_next;
      md_q   <= q_next;
    end
  end

  // EX/MEM output register. Flush has the highest priority. After that the
  // register loads a new single-cycle result or a finished mul/div result.
  // Otherwise it is emptied when the consumer takes it. It holds while
  // backpressured.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      alu_result  <= '0;
      store_data  <= '0;
      take_branch <= 1'b0;
      pc_in       <= '0;
      ovf         <= 1'b0;
      div_zero    <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      take_branch <= 1'b0;
    end else if (accept && !is_md) begin
      out_valid   <= 1'b1;
      alu_result  <= sc_result;
      store_data  <= rf_b;
      take_branch <= sc_take;
      pc_in       <= sc_pc;
      ovf         <= sc_ovf;
      div_zero    <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b0;
      take_branch <= 1'b0;
    end else if (md_done) begin
      out_valid   <= 1'b1;
      alu_result  <= md_result;
      store_data  <= md_store;
      take_branch <= 1'b0;
      pc_in       <= md_pc;
      ovf         <= md_ovf_fin;
      div_zero    <= md_dz;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
      take_branch <= 1'b0;
    end
  end

endmodule
